// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flagged FIFO: default geometry,
// pointer/count width calculation and wrap-aware pointer increment.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit compare so non-power-of-2 depths wrap correctly.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_flags_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface fifo_flags_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = cnt_width(DEPTH);

  logic             clear;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, wr_en, data_in, rd_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, data_in, rd_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset on the array.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flags.sv
// Show-ahead FIFO of arbitrary depth with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_flags_if.slave bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          is_full, is_empty;
  logic          wr_acc, rd_acc;

  assign is_full  = (count_reg == CW'(DEPTH));
  assign is_empty = (count_reg == '0);

  // A write into a full FIFO is fine when a pop frees the same slot this edge.
  assign wr_acc = bus.wr_en & (~is_full | bus.rd_en);
  assign rd_acc = bus.rd_en & ~is_empty;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (wr_acc) begin
      wr_ptr_next = PW'(next_ptr(int'(wr_ptr_reg), DEPTH));
    end
    if (rd_acc) begin
      rd_ptr_next = PW'(next_ptr(int'(rd_ptr_reg), DEPTH));
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    if (bus.wr_en & is_full & ~bus.rd_en) begin
      overflow_next = 1'b1;
    end
    if (bus.rd_en & is_empty) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & rst_n & ~bus.clear),
    .waddr (wr_ptr_reg),
    .wdata (bus.data_in),
    .raddr (rd_ptr_reg),
    .rdata (bus.data_out)
  );

  assign bus.count        = count_reg;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count_reg >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_reg <= CW'(AE_LEVEL));
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: a queue-based model checked every cycle against a
// DEPTH=4 and a DEPTH=5 instance, plus directed literal expectations.
module tb_fifo_flags;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_flags_if #(.WIDTH(8), .DEPTH(4)) a_if ();
  fifo_flags_if #(.WIDTH(8), .DEPTH(5)) b_if ();

  fifo_flags #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  fifo_flags #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Per-instance configuration, index 0 = dut_a, 1 = dut_b
  int depth [2] = '{4, 5};
  int af_lv [2] = '{3, 4};
  int ae_lv [2] = '{1, 2};

  logic       in_clr [2];
  logic       in_wr  [2];
  logic       in_rd  [2];
  logic [7:0] in_d   [2];
  logic [7:0] o_dout [2];
  logic [31:0] o_cnt [2];
  logic       o_full [2], o_empty [2], o_af [2], o_ae [2], o_ov [2], o_un [2];

  assign in_clr[0] = a_if.clear;   assign in_clr[1] = b_if.clear;
  assign in_wr[0]  = a_if.wr_en;   assign in_wr[1]  = b_if.wr_en;
  assign in_rd[0]  = a_if.rd_en;   assign in_rd[1]  = b_if.rd_en;
  assign in_d[0]   = a_if.data_in; assign in_d[1]   = b_if.data_in;
  assign o_dout[0] = a_if.data_out; assign o_dout[1] = b_if.data_out;
  assign o_cnt[0]  = 32'(a_if.count); assign o_cnt[1] = 32'(b_if.count);
  assign o_full[0] = a_if.full;  assign o_full[1] = b_if.full;
  assign o_empty[0] = a_if.empty; assign o_empty[1] = b_if.empty;
  assign o_af[0] = a_if.almost_full;  assign o_af[1] = b_if.almost_full;
  assign o_ae[0] = a_if.almost_empty; assign o_ae[1] = b_if.almost_empty;
  assign o_ov[0] = a_if.overflow;  assign o_ov[1] = b_if.overflow;
  assign o_un[0] = a_if.underflow; assign o_un[1] = b_if.underflow;

  // Behavioural model: a queue of stored words plus two sticky bits.
  logic [7:0] mq [2][$];
  logic       m_ov [2] = '{1'b0, 1'b0};
  logic       m_un [2] = '{1'b0, 1'b0};
  logic       model_ready = 1'b0;
  int         b_max = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int n;
      logic [7:0] popped;
      n = mq[k].size();
      if (!rst_n || in_clr[k]) begin
        mq[k].delete();
        m_ov[k] = 1'b0;
        m_un[k] = 1'b0;
      end else begin
        if (in_wr[k] && n == depth[k] && !in_rd[k]) m_ov[k] = 1'b1;
        if (in_rd[k] && n == 0) m_un[k] = 1'b1;
        if (in_rd[k] && n > 0) popped = mq[k].pop_front();
        if (in_wr[k] && (n < depth[k] || in_rd[k])) mq[k].push_back(in_d[k]);
      end
    end
    if (!rst_n) model_ready = 1'b1;
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, 0, act, exp);
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      for (int k = 0; k < 2; k++) begin
        int n;
        n = mq[k].size();
        check("count", k, o_cnt[k], 32'(n));
        check("full", k, 32'(o_full[k]), 32'(n == depth[k]));
        check("empty", k, 32'(o_empty[k]), 32'(n == 0));
        check("almost_full", k, 32'(o_af[k]), 32'(n >= af_lv[k]));
        check("almost_empty", k, 32'(o_ae[k]), 32'(n <= ae_lv[k]));
        check("overflow", k, 32'(o_ov[k]), 32'(m_ov[k]));
        check("underflow", k, 32'(o_un[k]), 32'(m_un[k]));
        if (n > 0) check("data_out", k, 32'(o_dout[k]), 32'(mq[k][0]));
      end
      if (int'(o_cnt[1]) > b_max) b_max = int'(o_cnt[1]);
    end
  end

  task automatic a_cyc(input logic w, input logic r, input logic [7:0] d);
    a_if.wr_en = w;
    a_if.rd_en = r;
    a_if.data_in = d;
    @(posedge clk);
    #1;
    a_if.wr_en = 1'b0;
    a_if.rd_en = 1'b0;
    a_if.clear = 1'b0;
  endtask

  initial begin
    int n_sent;
    logic acc;
    logic [7:0] w;
    a_if.clear = 0; a_if.wr_en = 0; a_if.rd_en = 0; a_if.data_in = 0;
    b_if.clear = 0; b_if.wr_en = 0; b_if.rd_en = 0; b_if.data_in = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    lit("rst_count", o_cnt[0], 0);
    lit("rst_empty", 32'(a_if.empty), 1);
    lit("rst_full", 32'(a_if.full), 0);
    lit("rst_ae", 32'(a_if.almost_empty), 1);
    lit("rst_af", 32'(a_if.almost_full), 0);

    a_cyc(1, 0, 8'hA1);
    lit("w1_count", o_cnt[0], 1);
    lit("w1_dout", 32'(a_if.data_out), 32'hA1);
    lit("w1_ae", 32'(a_if.almost_empty), 1);
    a_cyc(1, 0, 8'hA2);
    lit("w2_count", o_cnt[0], 2);
    lit("w2_ae", 32'(a_if.almost_empty), 0);
    lit("w2_af", 32'(a_if.almost_full), 0);
    a_cyc(1, 0, 8'hA3);
    lit("w3_count", o_cnt[0], 3);
    lit("w3_af", 32'(a_if.almost_full), 1);
    a_cyc(1, 0, 8'hA4);
    lit("w4_full", 32'(a_if.full), 1);
    a_cyc(1, 0, 8'hFF);
    lit("ovf_flag", 32'(a_if.overflow), 1);
    lit("ovf_count", o_cnt[0], 4);
    for (int i = 0; i < 4; i++) begin
      lit("pop_order", 32'(a_if.data_out), 32'(8'hA1 + i));
      a_cyc(0, 1, 8'h00);
    end
    lit("drained_empty", 32'(a_if.empty), 1);

    for (int i = 0; i < 4; i++) a_cyc(1, 0, 8'hB1 + 8'(i));
    a_cyc(1, 1, 8'h55);
    lit("wr_rd_full_count", o_cnt[0], 4);
    lit("wr_rd_full_dout", 32'(a_if.data_out), 32'hB2);
    for (int i = 0; i < 3; i++) a_cyc(0, 1, 8'h00);
    lit("wrapped_dout", 32'(a_if.data_out), 32'h55);
    lit("wrapped_count", o_cnt[0], 1);
    a_cyc(0, 1, 8'h00);

    a_cyc(1, 1, 8'h3C);
    lit("unf_flag", 32'(a_if.underflow), 1);
    lit("unf_count", o_cnt[0], 1);
    lit("unf_dout", 32'(a_if.data_out), 32'h3C);

    a_cyc(1, 0, 8'hD1);
    a_cyc(1, 0, 8'hD2);
    a_if.clear = 1'b1;
    a_if.wr_en = 1'b1;
    a_if.data_in = 8'h77;
    @(negedge clk);
    lit("pre_clear_count", o_cnt[0], 3);
    @(posedge clk);
    #1;
    a_if.clear = 1'b0;
    a_if.wr_en = 1'b0;
    lit("clr_count", o_cnt[0], 0);
    lit("clr_empty", 32'(a_if.empty), 1);
    lit("clr_ovf", 32'(a_if.overflow), 0);
    lit("clr_unf", 32'(a_if.underflow), 0);

    for (int i = 0; i < 4; i++) a_cyc(1, 0, 8'hE1 + 8'(i));
    a_cyc(1, 0, 8'hEE);
    a_cyc(0, 1, 8'h00);
    rst_n = 1'b0;
    a_if.wr_en = 1'b1;
    a_if.data_in = 8'h88;
    @(negedge clk);
    lit("pre_rst_count", o_cnt[0], 3);
    lit("pre_rst_ovf", 32'(a_if.overflow), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_if.wr_en = 1'b0;
    lit("rst2_count", o_cnt[0], 0);
    lit("rst2_empty", 32'(a_if.empty), 1);
    lit("rst2_ovf", 32'(a_if.overflow), 0);

    // DEPTH=5 stream: 12 words, reads start at cycle 5 and interleave
    n_sent = 0;
    for (int i = 0; i < 30; i++) begin
      w = 8'hC0 + 8'(n_sent);
      b_if.wr_en = (n_sent < 12);
      b_if.rd_en = (i >= 5) && ((i % 2) == 1 || i >= 14);
      b_if.data_in = w;
      acc = b_if.wr_en && (mq[1].size() < 5 || b_if.rd_en);
      @(posedge clk);
      #1;
      if (acc) n_sent++;
    end
    b_if.wr_en = 1'b0;
    b_if.rd_en = 1'b0;
    @(posedge clk);
    #1;
    check("b_sent", 1, 32'(n_sent), 12);
    check("b_empty", 1, 32'(b_if.empty), 1);
    check("b_max_count", 1, 32'(b_max), 5);
    check("b_ovf", 1, 32'(b_if.overflow), 1);
    check("b_unf", 1, 32'(b_if.underflow), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
Parametrised successor to the team's single-clock FIFO, used as the TX/RX buffer behind the SPI shift engines.
- Adds arbitrary (non-power-of-2) depth, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Guards against writes when full and reads when empty.
- Show-ahead (first-word-fall-through) read port: data_out presents the head entry whenever !empty.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2, any integer)
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset; one clock; reset is synchronous and active-low
clear  input  1  synchronous flush: pointers, count and error flags to zero
wr_en  input  1  write request
data_in  input  WIDTH  write data
rd_en  input  1  read request (pops the head entry)
data_out  output  WIDTH  head entry (show-ahead); valid only while !empty
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CW  occupancy, CW = $clog2(DEPTH+1)
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low at a clk edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0). Storage array is not reset; data_out is don't-care while empty.
- Priority at each edge: rst_n low > clear > normal operation. A clear cycle ignores wr_en/rd_en in that cycle.
- Accept rules (evaluated on pre-edge count):
  - wr_acc = wr_en & (!full | rd_en)
  - rd_acc = rd_en & !empty
- Full with wr_en & rd_en: both are accepted, count stays DEPTH, and the written word lands in the slot being freed.
- Empty with wr_en & rd_en: the write is accepted, the read is rejected, underflow sets, and count becomes 1.
- Pointers: wr_ptr advances on wr_acc and rd_ptr on rd_acc. Each wraps from DEPTH-1 to 0 by explicit compare; no reliance on binary wrap. Pointer width PW = $clog2(DEPTH).
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither. It is a register and never leaves 0..DEPTH.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from the registered count. They change in the cycle after the accepted operation, i.e. 1-cycle latency from the request edge.
- data_out = mem[rd_ptr], combinational from registered state.
  - After a write into an empty FIFO, data_out shows the word in the next cycle.
  - After a pop, the next entry appears in the next cycle.
- Error flags:
  - overflow sets on wr_en & full & !rd_en.
  - underflow sets on rd_en & empty.
  - Both hold until clear or reset. Rejected operations leave memory, pointers and count untouched.
- Memory write occurs only on wr_acc, at mem[wr_ptr].

Decomposition:
- Shared package fifo_pkg:
  - default WIDTH/DEPTH constants
  - width helper for CW/PW (clog2 of DEPTH and DEPTH+1)
  - pointer-increment-with-wrap function
- One sub-module: fifo_mem (WIDTH x DEPTH array).
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset.
- Control (pointers, count, flags) stays in fifo_flags.

Test Plan:
- WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1; reset then write 0xA1,0xA2,0xA3 on consecutive cycles.
  - count steps 1,2,3.
  - almost_empty drops when count=2; almost_full rises when count=3.
  - data_out=0xA1 from the cycle after the first write.
- Fill to 4, then assert wr_en alone with 0xFF -> full=1, overflow=1, count=4. Pop 4 times -> 0xA1,0xA2,0xA3,<4th> in order; 0xFF is never seen.
- Full, then wr_en & rd_en with 0x55 for one cycle -> count stays 4 and data_out advances. After 3 more pops data_out=0x55; pointers have wrapped.
- Empty, then wr_en & rd_en with 0x3C -> underflow=1, count=1, data_out=0x3C next cycle.
- DEPTH=5 (non-power-of-2), stream 12 words with interleaved reads -> output order matches input and count never exceeds 5.
- With count=3 and overflow=1, assert clear together with wr_en -> next cycle count=0, empty=1, overflow=0, write dropped. Repeat with rst_n low instead of clear -> same result, reset sampled only at the clk edge.
